// File: rtl/raster_lane_gen.sv
// Multi-lane raster coordinate generator: emits LANES adjacent pixel x coordinates
// per beat in raster order over an H_ACTIVE x V_ACTIVE frame, with valid/ready flow control.
module raster_lane_gen #(
  parameter int LANES    = 4,
  parameter int COORD_W  = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*COORD_W-1:0] x_out,
  output logic [COORD_W-1:0]       y_out,
  output logic                     sof,
  output logic                     eol,
  output logic                     busy,
  output logic                     frame_done
);

  if (H_ACTIVE % LANES != 0) begin : g_bad_lanes
    $error("raster_lane_gen: LANES must divide H_ACTIVE");
  end
  if ((longint'(H_ACTIVE) > (longint'(1) << COORD_W)) ||
      (longint'(V_ACTIVE) > (longint'(1) << COORD_W))) begin : g_bad_coord_w
    $error("raster_lane_gen: H_ACTIVE/V_ACTIVE exceed 2**COORD_W");
  end

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - LANES);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] X_STEP = COORD_W'(LANES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_base_q, x_base_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               frame_done_q, frame_done_d;

  logic xfer;
  logic at_x_last;
  logic at_y_last;

  assign xfer      = (state_q == RUN) && out_ready;
  assign at_x_last = (x_base_q == X_LAST);
  assign at_y_last = (y_q == Y_LAST);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    x_base_d     = x_base_q;
    y_d          = y_q;
    frame_done_d = 1'b0;

    if (abort) begin
      // Abort wins over start and over a transfer; the beat in flight is dropped.
      state_d  = IDLE;
      x_base_d = '0;
      y_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          if (xfer) begin
            if (!at_x_last) begin
              x_base_d = x_base_q + X_STEP;
            end else if (!at_y_last) begin
              x_base_d = '0;
              y_d      = y_q + COORD_W'(1);
            end else begin
              frame_done_d = 1'b1;
              x_base_d     = '0;
              y_d          = '0;
              if (!continuous) state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      x_base_q     <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_base_q     <= x_base_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign x_out[i*COORD_W +: COORD_W] = x_base_q + COORD_W'(i);
  end

  assign y_out      = y_q;
  assign out_valid  = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign sof        = (x_base_q == '0) && (y_q == '0);
  assign eol        = at_x_last;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_raster_lane_gen.sv
// Randomised self-checking bench for raster_lane_gen, using a beat-index reference model
// on a 4-lane 16x4 instance plus a directed check of a one-beat-per-line instance.
module tb_raster_lane_gen;

  localparam int L     = 4;
  localparam int W     = 10;
  localparam int H     = 16;
  localparam int V     = 4;
  localparam int BPL   = H / L;
  localparam int FRAME = BPL * V;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic           start, continuous, abort, out_ready;
  logic           out_valid, sof, eol, busy, frame_done;
  logic [L*W-1:0] x_out;
  logic [W-1:0]   y_out;

  logic           n_start, n_ready;
  logic           n_valid, n_sof, n_eol, n_busy, n_fd;
  logic [15:0]    n_x;
  logic [3:0]     n_y;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: a frame is just a beat index 0..FRAME-1.
  bit m_active;
  int m_idx;
  bit m_fd;

  int xfers, sof_seen, fd_seen;

  always #5 aclk = ~aclk;

  raster_lane_gen #(.LANES(L), .COORD_W(W), .H_ACTIVE(H), .V_ACTIVE(V)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .continuous(continuous),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
    .y_out(y_out), .sof(sof), .eol(eol), .busy(busy), .frame_done(frame_done)
  );

  raster_lane_gen #(.LANES(4), .COORD_W(4), .H_ACTIVE(4), .V_ACTIVE(3)) u_dut_narrow (
    .aclk(aclk), .aresetn(aresetn), .start(n_start), .continuous(1'b0),
    .abort(1'b0), .out_valid(n_valid), .out_ready(n_ready), .x_out(n_x),
    .y_out(n_y), .sof(n_sof), .eol(n_eol), .busy(n_busy), .frame_done(n_fd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [L*W-1:0] lanes_of(input int xb);
    logic [L*W-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = W'(xb + i);
    return r;
  endfunction

  task automatic check_outputs();
    int xb, yy;
    xb = (m_idx % BPL) * L;
    yy = m_idx / BPL;
    check("out_valid",  out_valid, m_active);
    check("busy",       busy, m_active);
    check("x_out",      x_out, lanes_of(xb));
    check("y_out",      y_out, yy);
    check("sof",        sof, (xb == 0) && (yy == 0));
    check("eol",        eol, xb == H - L);
    check("frame_done", frame_done, m_fd);
  endtask

  // One cycle: check at the falling edge, drive inputs, advance the model, wait a cycle.
  task automatic step(input logic st, input logic co, input logic ab, input logic rd);
    check_outputs();
    if (out_valid && rd && !ab) begin
      xfers++;
      if (sof) sof_seen++;
    end
    if (frame_done) fd_seen++;
    start = st; continuous = co; abort = ab; out_ready = rd;
    if (ab) begin
      m_active = 0; m_idx = 0; m_fd = 0;
    end else if (m_active) begin
      m_fd = 0;
      if (rd) begin
        if (m_idx == FRAME - 1) begin
          m_fd = 1; m_idx = 0; m_active = co;
        end else begin
          m_idx++;
        end
      end
    end else begin
      m_fd = 0;
      m_active = st;
    end
    @(negedge aclk);
  endtask

  task automatic clear_counts();
    xfers = 0; sof_seen = 0; fd_seen = 0;
  endtask

  initial begin
    aresetn = 1'b0;
    start = 0; continuous = 0; abort = 0; out_ready = 0;
    n_start = 0; n_ready = 0;
    m_active = 0; m_idx = 0; m_fd = 0;
    clear_counts();
    repeat (2) @(negedge aclk);
    check_outputs();
    aresetn = 1'b1;
    @(negedge aclk);

    // Single-shot frame with out_ready held high.
    clear_counts();
    step(1, 0, 0, 1);
    for (int k = 0; k < FRAME; k++) step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    check("single_xfers", xfers, FRAME);
    check("single_sof",   sof_seen, 1);
    check("single_fd",    fd_seen, 1);

    // start while running is ignored; random 50% backpressure.
    clear_counts();
    step(1, 0, 0, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 200 && m_active; k++)
      step(1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)));
    repeat (2) step(0, 0, 0, 1);
    check("bp_xfers", xfers, FRAME);
    check("bp_fd",    fd_seen, 1);

    // Continuous: three back-to-back frames, continuous dropped inside frame 3.
    clear_counts();
    step(1, 1, 0, 1);
    for (int k = 0; k < 3 * FRAME; k++) step(0, k < 2 * FRAME + 8, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    check("cont_xfers", xfers, 3 * FRAME);
    check("cont_sof",   sof_seen, 3);
    check("cont_fd",    fd_seen, 3);

    // Abort at x_base=8, y=2 together with out_ready, then start+abort in IDLE.
    clear_counts();
    step(1, 0, 0, 1);
    for (int k = 0; k < 200 && m_idx != 2 * BPL + 2; k++) step(0, 0, 0, 1);
    check("abort_pos_x", x_out, lanes_of(8));
    check("abort_pos_y", y_out, 2);
    step(0, 0, 1, 1);
    step(1, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    check("abort_fd", fd_seen, 0);

    // Random control mix, including stray aborts and starts.
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)));
    step(0, 0, 1, 0);

    // Asynchronous reset at beat 5 of a frame, checked before any clock edge.
    step(1, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1);
    aresetn = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_x",     x_out, lanes_of(0));
    check("rst_y",     y_out, 0);
    check("rst_sof",   sof, 1);
    m_active = 0; m_idx = 0; m_fd = 0;
    start = 0; out_ready = 0; abort = 0; continuous = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    step(0, 0, 0, 1);

    // One beat per line: sof and eol coincide on the first beat.
    n_start = 1;
    @(negedge aclk);
    n_start = 0; n_ready = 1;
    for (int b = 0; b < 3; b++) begin
      check("nar_valid", n_valid, 1);
      check("nar_x",     n_x, 16'h3210);
      check("nar_y",     n_y, b);
      check("nar_sof",   n_sof, b == 0);
      check("nar_eol",   n_eol, 1);
      @(negedge aclk);
    end
    check("nar_fd",    n_fd, 1);
    check("nar_idle",  n_valid, 0);
    check("nar_busy",  n_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
